// File: rtl/pipe_pkg.sv
// Shared defaults, beat layout and occupancy states for the IF/ID pipeline register.
package pipe_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc_plus1;
    logic [INSTR_W_DEF-1:0] instr;
  } if_id_beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register. Clear drops validity but keeps the payload;
// reset zeroes both.
module pipe_slot #(
  parameter int W = 44
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// IF/ID valid/ready pipeline register. Define PIPE_STAGE_SKID_EN for the
// two-slot skid variant with a registered in_ready; otherwise a single slot.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc_plus1,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc_plus1,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int W = ADDR_W + INSTR_W;

  logic [W-1:0] in_beat;
  logic [W-1:0] m_d;
  logic [W-1:0] m_q;
  logic         m_valid;
  logic         m_load;
  logic         m_clear;
  logic         accept;
  logic         consume;

  assign in_beat      = {in_pc_plus1, in_instr};
  assign consume      = m_valid && out_ready;
  // A beat handshaken during flush is dropped, never loaded.
  assign accept       = in_valid && in_ready && !flush;
  assign out_valid    = m_valid;
  assign out_pc_plus1 = m_q[W-1:INSTR_W];
  assign out_instr    = m_q[INSTR_W-1:0];

  pipe_slot #(.W(W)) u_m_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  state_t       state;
  logic [W-1:0] s_q;
  logic         s_valid;
  logic         s_load;
  logic         s_clear;

  assign in_ready = !s_valid;

  pipe_slot #(.W(W)) u_s_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (s_load),
    .clear (s_clear),
    .d     (in_beat),
    .valid (s_valid),
    .q     (s_q)
  );

  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_d     = in_beat;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: m_load = accept;
        ST_ONE: begin
          if (accept && !consume) s_load = 1'b1;
          else if (accept)        m_load = 1'b1;
          else if (consume)       m_clear = 1'b1;
        end
        ST_FULL: begin
          if (consume) begin
            m_load  = 1'b1;
            m_d     = s_q;
            s_clear = 1'b1;
          end
        end
        default: begin
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state <= ST_FULL;
          else if (!accept && consume) state <= ST_EMPTY;
        end
        ST_FULL:  if (consume) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end
`else
  // Single slot: a consuming slot can reload in the same cycle.
  assign in_ready = !m_valid || out_ready;

  always_comb begin
    m_d     = in_beat;
    m_load  = accept;
    m_clear = flush || (consume && !accept);
  end
`endif

endmodule
